// File: rtl/booth_sequencer.sv
// Radix-4 Booth multiply sequencer: folds ITERATIONS partial products from the
// operand datapath into a 130-bit accumulator, two multiplier bits per step.
module booth_sequencer #(
    parameter int ITERATIONS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [127:0]        shiftedMultiplicand,
    output logic [1:0]          op,
    output logic                busy,
    output logic                done,
    output logic signed [127:0] product
);
    localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        CALCULATING = 2'b01,
        DONE        = 2'b10
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    stepCount;
    logic signed [129:0] acc;

    // Add the partial product two bits above the LSB, then retire two bits
    // with an arithmetic shift so the running sum keeps its sign.
    function automatic logic signed [129:0] boothStep(
        input logic signed [129:0] accIn,
        input logic [127:0]        partial
    );
        logic signed [129:0] ext;
        logic signed [129:0] sum;
        ext = {{2{partial[127]}}, partial};
        sum = accIn + (ext <<< 2);
        return sum >>> 2;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            stepCount <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= CALCULATING;
                        stepCount <= '0;
                        acc       <= '0;
                        busy      <= 1'b1;
                    end
                end
                CALCULATING: begin
                    acc       <= boothStep(acc, shiftedMultiplicand);
                    stepCount <= stepCount + 1'b1;
                    if (stepCount == LAST_STEP) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // The unused encoding reads back as IDLE so the datapath never sees it.
    always_comb begin
        case (state)
            CALCULATING: op = 2'b01;
            DONE:        op = 2'b10;
            default:     op = 2'b00;
        endcase
    end

    assign product = acc[127:0];

endmodule

// File: tb/tb_booth_sequencer.sv
// Bench for booth_sequencer: directed vectors, multi-cycle corner cases and
// random operands on several parallel lanes, each with its own operand datapath.
module tb_booth_sequencer;
    localparam int NL   = 8;
    localparam int ITER = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                startV [NL];
    logic signed [63:0]  opAV   [NL];
    logic signed [63:0]  opBV   [NL];
    logic [1:0]          opV    [NL];
    logic                busyV  [NL];
    logic                doneV  [NL];
    logic signed [127:0] prodV  [NL];

    int checks = 0;
    int errors = 0;

    // Partial product for Booth digit k of multiplier y, pre-scaled so that
    // ITER accumulate-and-shift steps leave exactly m*y in the accumulator.
    function automatic logic signed [127:0] boothPP(input logic signed [63:0] m,
                                                    input logic [63:0] y, input int k);
        int d;
        logic signed [127:0] mx;
        logic lowBit;
        if (k < 0 || k >= ITER) return '0;
        lowBit = (k == 0) ? 1'b0 : y[2*k-1];
        d = int'(y[2*k]) + int'(lowBit) - 2 * int'(y[2*k+1]);
        mx = {{64{m[63]}}, m};
        return (mx * d) <<< 62;
    endfunction

    function automatic logic [127:0] refProd(input logic signed [63:0] a, input logic signed [63:0] b);
        logic signed [127:0] xa;
        logic signed [127:0] xb;
        xa = {{64{a[63]}}, a};
        xb = {{64{b[63]}}, b};
        return xa * xb;
    endfunction

    for (genvar g = 0; g < NL; g++) begin : lane
        logic signed [63:0] aReg;
        logic [63:0]        bReg;
        int                 step;
        logic [127:0]       sm;

        always @(posedge clk) begin
            if (opV[g] == 2'b00 && startV[g]) begin
                aReg <= opAV[g];
                bReg <= opBV[g];
                step <= 0;
            end else if (opV[g] == 2'b01) begin
                step <= step + 1;
            end
        end

        always_comb sm = boothPP(aReg, bReg, step);

        booth_sequencer #(.ITERATIONS(ITER)) dut (
            .clk                 (clk),
            .reset               (reset),
            .start               (startV[g]),
            .shiftedMultiplicand (sm),
            .op                  (opV[g]),
            .busy                (busyV[g]),
            .done                (doneV[g]),
            .product             (prodV[g])
        );
    end

    task automatic check128(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic checkInt(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    // Lane-0 monitors: product may only move on an edge that was calculating,
    // accepting a start, or resetting; done and busy are never both high.
    logic [127:0] prevProd;
    logic [1:0]   prevOp;
    logic         prevStart;
    logic         prevReset;
    logic         prevValid = 1'b0;

    always @(negedge clk) begin
        if (prevValid && prodV[0] !== prevProd) begin
            checks++;
            if (!(prevOp == 2'b01 || (prevOp == 2'b00 && prevStart) || prevReset)) begin
                errors++;
                $display("FAIL productStable got=%h want=%h", prodV[0], prevProd);
            end
        end
        checks++;
        if (busyV[0] && doneV[0]) begin
            errors++;
            $display("FAIL busyDoneExclusive got=1 want=0");
        end
        prevProd  <= prodV[0];
        prevOp    <= opV[0];
        prevStart <= startV[0];
        prevReset <= reset;
        prevValid <= 1'b1;
    end

    task automatic runMul(input logic signed [63:0] a, input logic signed [63:0] b,
                          input int p1, input int p2,
                          output logic [127:0] prod, output int lat, output int busyCnt);
        opAV[0] = a;
        opBV[0] = b;
        startV[0] = 1'b1;
        @(posedge clk); #1;
        startV[0] = 1'b0;
        busyCnt = busyV[0] ? 1 : 0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            startV[0] = (n == p1 || n == p2);
            @(posedge clk); #1;
            startV[0] = 1'b0;
            if (doneV[0]) begin
                lat = n;
                break;
            end
            if (busyV[0]) busyCnt++;
        end
        prod = prodV[0];
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL doneTimeout got=none want=done");
        end else begin
            checkInt("opDuringDone", int'(opV[0]), 2);
            @(posedge clk); #1;
            checkInt("donePulseWidth", int'(doneV[0]), 0);
            checkInt("idleAfterDone", int'(opV[0]), 0);
            check128("productHeld", prodV[0], prod);
        end
    endtask

    function automatic logic signed [63:0] rnd();
        case ($urandom_range(0, 9))
            0:       return 64'sd0;
            1:       return -64'sd1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    typedef struct {
        logic signed [63:0]  a;
        logic signed [63:0]  b;
        logic signed [127:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] got;
        logic [127:0] expv [NL];
        int lat, busyCnt, doneSeen, dones, cyc, lastDone;
        bit timedOut;

        vecs[0] = '{64'sd3,  64'sd5,  128'sd15};
        vecs[1] = '{-64'sd1, -64'sd1, 128'sd1};
        vecs[2] = '{-64'sd7, 64'sd6,  -128'sd42};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                    128'hC000_0000_0000_0000_8000_0000_0000_0000};
        vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                    128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001};
        vecs[6] = '{64'sd0,  64'h7FFF_FFFF_FFFF_FFFF, 128'sd0};
        vecs[7] = '{64'sd1,  -64'sd1, -128'sd1};

        reset = 1'b1;
        for (int l = 0; l < NL; l++) begin
            startV[l] = 1'b0;
            opAV[l] = '0;
            opBV[l] = '0;
        end
        startV[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkInt("resetOp", int'(opV[0]), 0);
        checkInt("resetBusy", int'(busyV[0]), 0);
        checkInt("resetDone", int'(doneV[0]), 0);
        check128("resetProduct", prodV[0], '0);
        startV[0] = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runMul(vecs[i].a, vecs[i].b, -1, -1, got, lat, busyCnt);
            check128($sformatf("vecProduct%0d", i), got, vecs[i].exp);
            checkInt($sformatf("vecLatency%0d", i), lat, ITER);
            checkInt($sformatf("vecBusyCycles%0d", i), busyCnt, ITER);
        end

        // Stray start pulses mid-multiply are ignored and never queued.
        runMul(64'sd123456789, -64'sd987654321, 5, 31, got, lat, busyCnt);
        check128("pulsedStartProduct", got, refProd(64'sd123456789, -64'sd987654321));
        checkInt("pulsedStartLatency", lat, ITER);
        @(posedge clk); #1;
        checkInt("noQueuedStart", int'(opV[0]), 0);

        // Start held high: one multiply every ITER+2 cycles.
        opAV[0] = 64'sd11;
        opBV[0] = -64'sd13;
        startV[0] = 1'b1;
        dones = 0;
        lastDone = -1;
        for (cyc = 1; cyc <= 120; cyc++) begin
            @(posedge clk); #1;
            if (doneV[0]) begin
                check128("heldStartProduct", prodV[0], -128'sd143);
                if (lastDone >= 0) checkInt("heldStartInterval", cyc - lastDone, ITER + 2);
                lastDone = cyc;
                dones++;
            end
        end
        checkInt("heldStartDoneCount", dones, 3);
        startV[0] = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (opV[0] == 2'b00) break;
        end

        // Reset in the middle of a multiply discards it.
        opAV[0] = 64'sd1234;
        opBV[0] = 64'sd5678;
        startV[0] = 1'b1;
        @(posedge clk); #1;
        startV[0] = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkInt("midResetOp", int'(opV[0]), 0);
        checkInt("midResetBusy", int'(busyV[0]), 0);
        checkInt("midResetDone", int'(doneV[0]), 0);
        check128("midResetProduct", prodV[0], '0);
        doneSeen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (doneV[0]) doneSeen++;
        end
        checkInt("noDoneAfterReset", doneSeen, 0);
        runMul(64'sd9, -64'sd4, -1, -1, got, lat, busyCnt);
        check128("afterResetProduct", got, -128'sd36);

        // Random operands on all lanes in lockstep.
        timedOut = 1'b0;
        for (int it = 0; it < 1250 && !timedOut; it++) begin
            for (int l = 0; l < NL; l++) begin
                opAV[l] = rnd();
                opBV[l] = rnd();
                expv[l] = refProd(opAV[l], opBV[l]);
                startV[l] = 1'b1;
            end
            @(posedge clk); #1;
            for (int l = 0; l < NL; l++) startV[l] = 1'b0;
            lat = -1;
            for (int n = 1; n <= 40; n++) begin
                @(posedge clk); #1;
                if (doneV[0]) begin
                    lat = n;
                    break;
                end
            end
            if (lat < 0) begin
                checks++;
                errors++;
                $display("FAIL randomDoneTimeout got=none want=done");
                timedOut = 1'b1;
            end else begin
                for (int l = 0; l < NL; l++) begin
                    checks++;
                    if (!doneV[l] || prodV[l] !== expv[l]) begin
                        errors++;
                        $display("FAIL randomProduct lane%0d a=%h b=%h got=%h want=%h",
                                 l, opAV[l], opBV[l], prodV[l], expv[l]);
                    end
                end
                @(posedge clk); #1;
                for (int l = 0; l < NL; l++) begin
                    checks++;
                    if (prodV[l] !== expv[l]) begin
                        errors++;
                        $display("FAIL randomHold lane%0d got=%h want=%h", l, prodV[l], expv[l]);
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_sequencer.md
BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 Parameter: ITERATIONS, 32, number of radix-4 Booth steps per multiply (64-bit operands).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request a new multiply; operands presented on the operand/multiplicand datapath start inputs in the same cycle.
REQ-006 Port: shiftedMultiplicand  input  128  Booth partial product from the operand datapath for the current multiplier triplet.
REQ-007 Port: op  output  2  datapath command: 2'b00 IDLE, 2'b01 CALCULATING, 2'b10 DONE.
REQ-008 Port: busy  output  1  high while a multiply is in progress (state CALCULATING).
REQ-009 Port: done  output  1  one-cycle pulse, product valid.
REQ-010 Port: product  output  128  signed result, held stable until the next accepted start.

Function
REQ-011 States IDLE, CALCULATING, DONE; op SHALL equal the state encoding combinationally; 2'b11 is unreachable and SHALL decode as IDLE.
REQ-012 IDLE: start=1 at an edge -> CALCULATING, step counter cleared to 0, accumulator cleared to 0; start=0 -> remain IDLE.
REQ-013 The external operand registers load in the IDLE cycle where start is sampled (op=IDLE), so the first CALCULATING cycle sees the new operands.
REQ-014 CALCULATING, every edge: acc <= (acc + (sext130(shiftedMultiplicand) << 2)) >>> 2 (130-bit accumulator, arithmetic shift), counter increments.
REQ-015 CALCULATING with counter = ITERATIONS-1 at an edge: perform the final step and go to DONE; exactly ITERATIONS accumulation steps per multiply.
REQ-016 DONE: done=1 for exactly one cycle, op=DONE (datapath holds operands), then unconditionally -> IDLE.
REQ-017 product SHALL equal acc[127:0]; after DONE it equals the exact 128-bit two's-complement product of the two 64-bit signed operands.
REQ-018 product SHALL only change during CALCULATING; it holds its value through DONE and IDLE until the next accepted start clears it.
REQ-019 start while in CALCULATING or DONE SHALL be ignored (no restart, no queueing); a start held high through DONE is accepted in the following IDLE cycle.
REQ-020 Latency: done asserts in the cycle beginning ITERATIONS edges after the edge that accepted start (32 edges at default); back-to-back throughput one multiply per ITERATIONS+2 cycles.
REQ-021 busy=1 exactly in CALCULATING; done and busy SHALL never be high simultaneously.
REQ-022 Counter width ceil(log2(ITERATIONS)) bits; it SHALL not wrap during a multiply.

Reset
REQ-023 reset=1 at an edge: state IDLE, op=2'b00, counter 0, acc/product 0, busy 0, done 0; it takes priority over start and over any state, including mid-CALCULATING (in-flight multiply discarded, no done pulse).
REQ-024 After reset deassertion, the first start is accepted on the first edge it is sampled high.

Verification
REQ-025 start with operands 3 and 5 -> busy high 32 cycles, done pulse 32 edges after acceptance, product = 15.
REQ-026 operands -1 and -1 -> product = 1; operands -7 and 6 -> product = 128'hFFFF...FFD6 (-42).
REQ-027 operands 64'h8000_0000_0000_0000 twice -> product = 2^126 (128'h4000_0000_..._0000); 64'h7FFF_FFFF_FFFF_FFFF and 64'h8000_0000_0000_0000 -> -(2^126 - 2^63).
REQ-028 start pulsed again at cycles 5 and 31 of a running multiply -> no effect, single done pulse, correct product; start held high continuously -> multiplies every 34 cycles.
REQ-029 reset asserted at step 17 of a multiply -> next cycle op=00, busy=0, product=0, no done; a fresh multiply 9 x -4 then returns -36.
REQ-030 Random signed 64-bit operand pairs (at least 10,000) -> product matches a 128-bit signed reference model, product stable between done and next start.
